// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types for the Morse decoder front end and controller.
//                click_t is the event code carried on the click bus;
//                press_state_t is the press classifier state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        CLK_NONE = 2'b00,
        CLK_DOT  = 2'b01,
        CLK_DASH = 2'b10,
        CLK_END  = 2'b11
    } click_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_FLUSH = 2'd3
    } press_state_t;

endpackage
`default_nettype wire

// File: rtl/morse_press_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_press_classifier_if
//  Description : Signal bundle between the key/tick source and the press
//                classifier.
//                  tick_en  - slow timing tick (one clk wide)
//                  bi       - raw key input, high = pressed
//                  click    - event code, valid while enable is high
//                  enable   - one-cycle event strobe
//                  elem_cnt - elements emitted in the current letter
//                  err      - stuck-key flag
//                  key_db   - debounced key level
//                master: drives tick_en/bi; slave: the classifier.
//  Revision    : 1.0  initial release
// ============================================================================
interface morse_press_classifier_if;
    import morse_pkg::*;

    logic       tick_en;
    logic       bi;
    click_t     click;
    logic       enable;
    logic [2:0] elem_cnt;
    logic       err;
    logic       key_db;

    modport master (
        output tick_en, bi,
        input  click, enable, elem_cnt, err, key_db
    );

    modport slave (
        input  tick_en, bi,
        output click, enable, elem_cnt, err, key_db
    );
endinterface
`default_nettype wire

// File: rtl/morse_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : morse_debounce
//  Description : 2-flop synchroniser plus tick-based debounce of the raw key.
//                o_key_db changes only after the synchronised level has
//                differed from it for DEBOUNCE_TICKS consecutive ticks.
//                o_rise/o_fall pulse for one clk in the cycle o_key_db has
//                just changed.
//  Ports       : clk, mr (async active-high), i_tick_en, i_bi,
//                o_key_db, o_rise, o_fall
//  Revision    : 1.0  initial release
// ============================================================================
module morse_debounce #(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  wire logic clk,
    input  wire logic mr,
    input  wire logic i_tick_en,
    input  wire logic i_bi,
    output logic      o_key_db,
    output logic      o_rise,
    output logic      o_fall
);
    localparam int              DB_W      = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_key_db;
    logic            r_rise;
    logic            r_fall;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_key_db <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_bi;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            // Any tick where the input agrees with the debounced level
            // restarts the stability window.
            if (r_sync2 == r_key_db) begin
                r_cnt <= '0;
            end else if (i_tick_en) begin
                if (r_cnt == c_DB_LAST) begin
                    r_cnt    <= '0;
                    r_key_db <= ~r_key_db;
                    r_rise   <= ~r_key_db;
                    r_fall   <= r_key_db;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_key_db = r_key_db;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
endmodule
`default_nettype wire

// File: rtl/morse_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : morse_press_classifier
//  Description : Times debounced presses and releases of the Morse key and
//                emits one-cycle dot / dash / letter-end events.
//  Ports       : clk     - system clock
//                mr      - master reset, asynchronous, active-high
//                bus     - morse_press_classifier_if.slave (tick_en, bi in;
//                          click, enable, elem_cnt, err, key_db out)
//  Revision    : 1.0  initial release
// ============================================================================
module morse_press_classifier
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_TICKS   = 10,
    parameter int DOT_MAX_TICKS    = 250,
    parameter int LETTER_GAP_TICKS = 600,
    parameter int STUCK_TICKS      = 3000,
    parameter int MAX_ELEMENTS     = 5,
    parameter int CNT_W            = 12
) (
    input wire logic                 clk,
    input wire logic                 mr,
    morse_press_classifier_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_DOT_MAX = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] c_GAP     = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] c_STUCK   = CNT_W'(STUCK_TICKS);
    localparam logic [2:0]       c_MAX_EL  = 3'(MAX_ELEMENTS);

    logic w_key_db;
    logic w_rise;
    logic w_fall;

    morse_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .clk       (clk),
        .mr        (mr),
        .i_tick_en (bus.tick_en),
        .i_bi      (bus.bi),
        .o_key_db  (w_key_db),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    press_state_t     r_state;
    logic [CNT_W-1:0] r_press_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [2:0]       r_elem_cnt;
    logic             r_err;
    click_t           r_click;
    logic             r_enable;
    logic             r_rise_pend;   // rise seen while flushing, served from IDLE

    logic [CNT_W-1:0] w_press_inc;
    logic [CNT_W-1:0] w_gap_inc;
    logic [2:0]       w_elem_inc;

    assign w_press_inc = r_press_cnt + 1'b1;
    assign w_gap_inc   = r_gap_cnt + 1'b1;
    assign w_elem_inc  = r_elem_cnt + 1'b1;

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            r_state     <= ST_IDLE;
            r_press_cnt <= '0;
            r_gap_cnt   <= '0;
            r_elem_cnt  <= '0;
            r_err       <= 1'b0;
            r_click     <= CLK_NONE;
            r_enable    <= 1'b0;
            r_rise_pend <= 1'b0;
        end else begin
            r_click  <= CLK_NONE;
            r_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise || r_rise_pend) begin
                        r_state     <= ST_PRESS;
                        r_press_cnt <= '0;
                        r_err       <= 1'b0;
                        r_rise_pend <= 1'b0;
                    end
                end
                ST_PRESS: begin
                    if (w_fall) begin
                        if (!r_err) begin
                            r_enable   <= 1'b1;
                            r_click    <= (r_press_cnt < c_DOT_MAX) ? CLK_DOT : CLK_DASH;
                            r_elem_cnt <= w_elem_inc;
                            if (w_elem_inc == c_MAX_EL) begin
                                r_state <= ST_FLUSH;
                            end else begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= '0;
                            end
                        end else if (r_elem_cnt != 3'd0) begin
                            // Stuck press is dropped but the letter so far is closed.
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.tick_en && (r_press_cnt != c_STUCK)) begin
                        r_press_cnt <= w_press_inc;
                        if (w_press_inc == c_STUCK) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // A rise outranks a coincident gap terminal count.
                    if (w_rise) begin
                        r_state     <= ST_PRESS;
                        r_press_cnt <= '0;
                        r_err       <= 1'b0;
                    end else if (bus.tick_en) begin
                        if (w_gap_inc == c_GAP) begin
                            r_enable   <= 1'b1;
                            r_click    <= CLK_END;
                            r_elem_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= w_gap_inc;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_enable   <= 1'b1;
                    r_click    <= CLK_END;
                    r_elem_cnt <= '0;
                    r_state    <= ST_IDLE;
                    if (w_rise) begin
                        r_rise_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.click    = r_click;
    assign bus.enable   = r_enable;
    assign bus.elem_cnt = r_elem_cnt;
    assign bus.err      = r_err;
    assign bus.key_db   = w_key_db;
endmodule
`default_nettype wire
